// File: rtl/hififo_rc_if.sv
// Receive-stream and realigned-completion bus between the PCIe core side and the
// completion parser; master drives the receive beats, slave produces rc_* words.
interface hififo_rc_if;
  logic        rx_valid;
  logic        rx_last;
  logic [63:0] rx_data;
  logic        rc_valid;
  logic [7:0]  rc_tag;
  logic [5:0]  rc_index;
  logic [63:0] rc_data;
  logic [15:0] err_count;

  modport master (
    output rx_valid, rx_last, rx_data,
    input  rc_valid, rc_tag, rc_index, rc_data, err_count
  );

  modport slave (
    input  rx_valid, rx_last, rx_data,
    output rc_valid, rc_tag, rc_index, rc_data, err_count
  );
endinterface

// File: rtl/hififo_rc_parser.sv
// Keeps successful CplD TLPs from the 64-bit receive stream, realigns the
// 3-DW-header payload to 64-bit words and tags each word with tag and index.
//
// state | meaning
// HDR0  | waiting for header beat 0 (fmt/type, length, status, byte count)
// HDR1  | header beat 1: tag and first payload DW
// DATA  | payload beats, one realigned word per beat
// DROP  | discarding beats until rx_last
module hififo_rc_parser #(
  parameter int REQ_BYTES = 512
) (
  input logic        clock,
  input logic        reset,
  hififo_rc_if.slave rc_bus
);

  typedef enum logic [1:0] {HDR0, HDR1, DATA, DROP} state_t;

  localparam logic [12:0] REQ_BC = 13'(REQ_BYTES);

  state_t      state;
  state_t      state_nxt;
  logic        err_inc;
  logic        ld_hdr;
  logic        ld_tag;
  logic        emit;

  logic [6:0]  words_left;
  logic [5:0]  index;
  logic [7:0]  tag;
  logic [31:0] held;

  logic        rc_valid;
  logic [7:0]  rc_tag;
  logic [5:0]  rc_index;
  logic [63:0] rc_data;
  logic [15:0] err_count;

  logic [10:0] len_dw;
  logic [12:0] byte_cnt;
  logic        cpl_class;
  logic        accept;
  logic [5:0]  start_idx;

  // Zero-valued length / byte count fields encode their maximum.
  assign len_dw    = (rc_bus.rx_data[9:0] == 10'd0) ? 11'd1024 : {1'b0, rc_bus.rx_data[9:0]};
  assign byte_cnt  = (rc_bus.rx_data[43:32] == 12'd0) ? 13'd4096 : {1'b0, rc_bus.rx_data[43:32]};
  assign cpl_class = (rc_bus.rx_data[28:27] == 2'b01);
  assign accept    = (rc_bus.rx_data[31:24] == 8'h4A) &&
                     (rc_bus.rx_data[47:45] == 3'd0) &&
                     !len_dw[0] &&
                     (byte_cnt <= REQ_BC) &&
                     ({len_dw, 2'b00} <= byte_cnt);
  // 0x200 - byte_count modulo 512 is just the 9-bit negation.
  assign start_idx = 6'((9'd0 - byte_cnt[8:0]) >> 3);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= HDR0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    err_inc   = 1'b0;
    ld_hdr    = 1'b0;
    ld_tag    = 1'b0;
    emit      = 1'b0;
    if (rc_bus.rx_valid) begin
      case (state)
        HDR0: begin
          if (rc_bus.rx_last) begin
            err_inc = cpl_class;
          end else if (accept) begin
            ld_hdr    = 1'b1;
            state_nxt = HDR1;
          end else begin
            err_inc   = cpl_class;
            state_nxt = DROP;
          end
        end
        HDR1: begin
          if (rc_bus.rx_last) begin
            err_inc   = 1'b1;
            state_nxt = HDR0;
          end else begin
            ld_tag    = 1'b1;
            state_nxt = DATA;
          end
        end
        DATA: begin
          emit = 1'b1;
          if (words_left == 7'd1) begin
            if (rc_bus.rx_last) begin
              state_nxt = HDR0;
            end else begin
              err_inc   = 1'b1;
              state_nxt = DROP;
            end
          end else if (rc_bus.rx_last) begin
            err_inc   = 1'b1;
            state_nxt = HDR0;
          end
        end
        DROP: begin
          if (rc_bus.rx_last) begin
            state_nxt = HDR0;
          end
        end
        default: state_nxt = HDR0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      words_left <= '0;
      index      <= '0;
      tag        <= '0;
      held       <= '0;
      rc_valid   <= 1'b0;
      rc_tag     <= '0;
      rc_index   <= '0;
      rc_data    <= '0;
      err_count  <= '0;
    end else begin
      rc_valid <= emit;
      if (ld_hdr) begin
        words_left <= len_dw[7:1];
        index      <= start_idx;
      end
      if (ld_tag) begin
        tag  <= rc_bus.rx_data[15:8];
        held <= rc_bus.rx_data[63:32];
      end
      if (emit) begin
        rc_data    <= {rc_bus.rx_data[31:0], held};
        rc_index   <= index;
        rc_tag     <= tag;
        held       <= rc_bus.rx_data[63:32];
        index      <= index + 6'd1;
        words_left <= words_left - 7'd1;
      end
      if (err_inc && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

  assign rc_bus.rc_valid  = rc_valid;
  assign rc_bus.rc_tag    = rc_tag;
  assign rc_bus.rc_index  = rc_index;
  assign rc_bus.rc_data   = rc_data;
  assign rc_bus.err_count = err_count;

endmodule
